// File: rtl/beep_scheduler.sv
// rtl/beep_scheduler.sv - beeper arbiter: key/hour/alarm requests to timed 512 Hz / 1 kHz tone enables
module beep_scheduler #(
  parameter int MS_DIV  = 100000,
  parameter int BEEP_MS = 100,
  parameter int GAP_MS  = 100
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       req_key,
  input  logic       req_hour,
  input  logic       req_alarm,
  output logic       open512,
  output logic       open1k,
  output logic [1:0] grant,
  output logic       busy
);

  localparam int ON_CYC  = BEEP_MS * MS_DIV;
  localparam int OFF_CYC = GAP_MS * MS_DIV;
  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] G_NONE  = 2'b00;
  localparam logic [1:0] G_KEY   = 2'b01;
  localparam logic [1:0] G_HOUR  = 2'b10;
  localparam logic [1:0] G_ALARM = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF} state_e;

  state_e          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            beeps_q, beeps_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_key_q, pend_key_d;
  logic            pend_hour_q, pend_hour_d;
  logic            open512_q, open512_d;
  logic            open1k_q, open1k_d;
  logic            arb;
  logic            key_grant;
  logic            hour_grant;

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= G_NONE;
      beeps_q     <= 1'b0;
      cnt_q       <= '0;
      pend_key_q  <= 1'b0;
      pend_hour_q <= 1'b0;
      open512_q   <= 1'b0;
      open1k_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      beeps_q     <= beeps_d;
      cnt_q       <= cnt_d;
      pend_key_q  <= pend_key_d;
      pend_hour_q <= pend_hour_d;
      open512_q   <= open512_d;
      open1k_q    <= open1k_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    beeps_d    = beeps_q;
    cnt_d      = cnt_q;
    arb        = 1'b0;
    key_grant  = 1'b0;
    hour_grant = 1'b0;

    // beeps_q holds the beeps still owed after the current one (only hour owes one)
    case (state_q)
      S_IDLE: arb = 1'b1;
      S_ON: begin
        if (cnt_q == ON_LAST) begin
          state_d = S_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_OFF: begin
        if (cnt_q == OFF_LAST) begin
          if (beeps_q) begin
            state_d = S_ON;
            cnt_d   = '0;
            beeps_d = 1'b0;
          end else begin
            arb = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
    endcase

    // An alarm preempts a key or hour pattern outright; the preempted beep is dropped
    if (state_q != S_IDLE && req_alarm && grant_q != G_ALARM) begin
      state_d = S_ON;
      grant_d = G_ALARM;
      cnt_d   = '0;
      beeps_d = 1'b0;
      arb     = 1'b0;
    end

    if (arb) begin
      cnt_d   = '0;
      beeps_d = 1'b0;
      if (req_alarm) begin
        state_d = S_ON;
        grant_d = G_ALARM;
      end else if (pend_hour_q) begin
        state_d    = S_ON;
        grant_d    = G_HOUR;
        beeps_d    = 1'b1;
        hour_grant = 1'b1;
      end else if (pend_key_q) begin
        state_d   = S_ON;
        grant_d   = G_KEY;
        key_grant = 1'b1;
      end else begin
        state_d = S_IDLE;
        grant_d = G_NONE;
      end
    end

    pend_key_d  = req_key  | (pend_key_q  & ~key_grant);
    pend_hour_d = req_hour | (pend_hour_q & ~hour_grant);
  end

  always_comb begin
    open512_d = (state_d == S_ON) && (grant_d == G_KEY);
    open1k_d  = (state_d == S_ON) && grant_d[1];
  end

  assign open512 = open512_q;
  assign open1k  = open1k_q;
  assign grant   = grant_q;
  assign busy    = (grant_q != G_NONE);

endmodule

// File: tb/tb_beep_scheduler.sv
// tb/tb_beep_scheduler.sv - scoreboard bench for beep_scheduler (ON 8 cycles, OFF 4 cycles)
module tb_beep_scheduler;

  logic       clock = 1'b0;
  logic       rst;
  logic       req_key;
  logic       req_hour;
  logic       req_alarm;
  logic       open512;
  logic       open1k;
  logic [1:0] grant;
  logic       busy;

  beep_scheduler #(.MS_DIV(4), .BEEP_MS(2), .GAP_MS(1)) dut (
    .clock     (clock),
    .rst       (rst),
    .req_key   (req_key),
    .req_hour  (req_hour),
    .req_alarm (req_alarm),
    .open512   (open512),
    .open1k    (open1k),
    .grant     (grant),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] g;
    logic       o512;
    logic       o1k;
    int         sc;
  } exp_t;

  exp_t  exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    cur_sc = 0;
  string sc_names[8] = '{"reset", "key_single", "hour_double", "key_hour_same_edge",
                         "alarm_abort_key", "alarm_held", "rst_mid_hour", "key_replay_merge"};

  // One expected output tuple per clock edge; checked just after the edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (grant !== e.g || open512 !== e.o512 || open1k !== e.o1k || busy !== (e.g != 2'b00)) begin
        n_err++;
        $display("FAIL %s @%0t: got grant=%b open512=%b open1k=%b busy=%b, expected grant=%b open512=%b open1k=%b busy=%b",
                 sc_names[e.sc], $time, grant, open512, open1k, busy,
                 e.g, e.o512, e.o1k, (e.g != 2'b00));
      end
    end
  end

  task automatic push(input int n, input logic [1:0] g, input logic a, input logic b);
    exp_t e;
    e.g = g; e.o512 = a; e.o1k = b; e.sc = cur_sc;
    repeat (n) exp_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    push(n, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic push_key();
    push(8, 2'b01, 1'b1, 1'b0);
    push(4, 2'b01, 1'b0, 1'b0);
  endtask

  task automatic push_hour();
    repeat (2) begin
      push(8, 2'b10, 1'b0, 1'b1);
      push(4, 2'b10, 1'b0, 1'b0);
    end
  endtask

  task automatic push_alarm_beep();
    push(8, 2'b11, 1'b0, 1'b1);
    push(4, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst = 1'b1; req_key = 1'b0; req_hour = 1'b0; req_alarm = 1'b0;

    cur_sc = 0;
    push_idle(3);
    repeat (3) tick();
    rst = 1'b0;
    drain();

    // key pulse sampled at edge 0
    cur_sc = 1;
    req_key = 1'b1;
    push_idle(1); push_key(); push_idle(2);
    tick(); req_key = 1'b0;
    drain();

    cur_sc = 2;
    req_hour = 1'b1;
    push_idle(1); push_hour(); push_idle(2);
    tick(); req_hour = 1'b0;
    drain();

    cur_sc = 3;
    req_key = 1'b1; req_hour = 1'b1;
    push_idle(1); push_hour(); push_key(); push_idle(2);
    tick(); req_key = 1'b0; req_hour = 1'b0;
    drain();

    // alarm sampled at edge 3, dropped after edge 16 (inside its second ON)
    cur_sc = 4;
    req_key = 1'b1;
    push_idle(1); push(2, 2'b01, 1'b1, 1'b0);
    push_alarm_beep(); push_alarm_beep(); push_idle(2);
    tick(); req_key = 1'b0;
    repeat (2) tick(); req_alarm = 1'b1;
    repeat (14) tick(); req_alarm = 1'b0;
    drain();

    // alarm from idle held for edges 0..29, dropped during the third ON
    cur_sc = 5;
    req_alarm = 1'b1;
    repeat (3) push_alarm_beep();
    push_idle(2);
    repeat (30) tick(); req_alarm = 1'b0;
    drain();

    // reset lands on edge 15 (second hour beep); a req_hour on that edge must be ignored
    cur_sc = 6;
    req_hour = 1'b1;
    push_idle(1);
    push(8, 2'b10, 1'b0, 1'b1); push(4, 2'b10, 1'b0, 1'b0); push(2, 2'b10, 1'b0, 1'b1);
    push_idle(3);
    tick(); req_hour = 1'b0;
    repeat (14) tick(); rst = 1'b1; req_hour = 1'b1;
    tick(); rst = 1'b0; req_hour = 1'b0;
    drain();
    req_hour = 1'b1;
    push_idle(1); push_hour(); push_idle(2);
    tick(); req_hour = 1'b0;
    drain();

    // key re-requested twice during its own pattern: replayed exactly once
    cur_sc = 7;
    req_key = 1'b1;
    push_idle(1); push_key(); push_key(); push_idle(2);
    tick(); req_key = 1'b0;
    repeat (4) tick(); req_key = 1'b1;
    tick(); req_key = 1'b0;
    tick(); req_key = 1'b1;
    tick(); req_key = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/beep_scheduler.md
BEEP_SCHEDULER -- requirements
Module: beep_scheduler

Interface
REQ-001 Parameter MS_DIV, default 100000, meaning clock cycles per millisecond.
REQ-002 Parameter BEEP_MS, default 100, meaning tone-on time per beep in ms (>=1).
REQ-003 Parameter GAP_MS, default 100, meaning silent time after each beep in ms (>=1).
REQ-004 Port clock  in  1  single system clock; all logic on rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port req_key  in  1  one-cycle pulse requesting one beep on the 512 Hz tone.
REQ-007 Port req_hour  in  1  one-cycle pulse requesting two beeps on the 1 kHz tone.
REQ-008 Port req_alarm  in  1  level; repeated beeps on the 1 kHz tone while high.
REQ-009 Port open512  out  1  registered enable for the beeper's 512 Hz tone.
REQ-010 Port open1k  out  1  registered enable for the beeper's 1 kHz tone.
REQ-011 Port grant  out  2  owner of the beeper: 00 none, 01 key, 10 hour, 11 alarm.
REQ-012 Port busy  out  1  high whenever grant != 00.

Function
REQ-013 FSM states IDLE, ON, OFF; state, grant, beep counter and cycle counter are registered.
REQ-014 pend_key/pend_hour set on the edge a request pulse is sampled; cleared on the edge the request is granted; a set on the same edge as a clear wins.
REQ-015 A request arriving while the same request is already pending merges into it (no count).
REQ-016 A request arriving while its own pattern is being served sets pending; the pattern is served again after the current one ends.
REQ-017 Priority at grant: req_alarm > pend_hour > pend_key.
REQ-018 IDLE with a request at edge k: state ON, grant updated, tone output high at edge k+1 (tone high 1 cycle after a pulse is sampled).
REQ-019 ON lasts exactly BEEP_MS*MS_DIV cycles, OFF exactly GAP_MS*MS_DIV cycles; cycle counter cleared on every state entry.
REQ-020 Beep counts: key 1, hour 2, alarm unbounded; after the OFF of the last beep -> IDLE if no request, else directly ON for the next winner (no idle cycle).
REQ-021 Tone mapping: grant 01 drives open512; grant 10 or 11 drives open1k; tone high only in ON; open512 and open1k never high together.
REQ-022 req_alarm rising while grant is 01 or 10: current pattern aborted, its beep discarded (pending flag of aborted source not restored), next edge ON with grant 11, counters cleared.
REQ-023 req_alarm falling during alarm: current ON/OFF period completes; at end of that OFF (or ON->OFF then OFF) pattern ends normally per REQ-020.
REQ-024 Simultaneous req_key and req_hour: both pend; hour served, then key back-to-back.
REQ-025 Counters sized for BEEP_MS*MS_DIV and GAP_MS*MS_DIV without overflow; no wrap occurs in any state.

Reset
REQ-026 rst high at an edge: state IDLE, grant 00, busy 0, open512 0, open1k 0, pending flags and counters 0.
REQ-027 rst mid-pattern aborts it; requests sampled on reset edges are ignored; first request after rst release behaves per REQ-018.

Verification (MS_DIV=4, BEEP_MS=2, GAP_MS=1: ON 8 cycles, OFF 4 cycles)
REQ-028 Reset then req_key pulse at edge 0 -> open512 high edges 1-8, low 9-12, grant 01 edges 1-12, IDLE/grant 00 at edge 13.
REQ-029 req_hour pulse -> open1k high 8 cycles, low 4, high 8, low 4; grant 10 for 24 cycles; open512 stays 0.
REQ-030 req_key and req_hour same edge -> hour pattern (24 cycles) then key pattern starts next edge with grant 01, no idle gap.
REQ-031 req_alarm raised at cycle 3 of a key beep -> next edge open512 0, open1k 1, grant 11; key not replayed after alarm.
REQ-032 req_alarm held 30 cycles then dropped mid-ON -> beeps repeat 8/4, finishing ON and OFF, then IDLE, busy 0.
REQ-033 rst asserted during hour beep 2 -> next edge all outputs 0; req_hour pulse after release restarts full two-beep pattern.
